mem_sram_ctrl: RTL and testbench
================================

// Module: mem_sram_ctrl
// PURPOSE
//  Memory-side stage directly downstream of the LC-3 processor's MAR/MDR and memory strobes.
//  Turns the processor's level-held strobes into timed SRAM cycles and returns read data for MDR.
//  Handles the memory-mapped I/O word at IO_ADDR: switches S on read, hex display register on write.
//  Pulses Mem_ready once per completed access so the ISDU can leave its memory wait states.
// PARAMETERS
//  WAIT_CYCLES  2         SRAM access/pulse length in clocks, >=1
//  IO_ADDR      16'hFFFF  address decoded as I/O, never forwarded to SRAM
//  SRAM_AW      20        SRAM address width; upper bits zero-extended from ADDR
// PORTS
//  Clk           in    1        system clock, all state on rising edge
//  Reset         in    1        synchronous, active-high
//  ADDR          in    16       address from processor MAR
//  CE,UB,LB      in    1 each   processor chip enable / byte lanes, active-low
//  OE,WE         in    1 each   processor read / write strobes, active-low, level-held
//  Data_from_CPU in    16       write data (MDR contents)
//  Data_to_CPU   out   16       read data for MDR load
//  Mem_ready     out   1        one-cycle completion pulse
//  S             in    16       switch inputs (I/O read source)
//  Hex_data      out   16       hex display register (I/O write target)
//  SRAM_ADDR     out   SRAM_AW  SRAM address
//  SRAM_DQ       inout 16       SRAM data, driven only during write states
//  SRAM_CE_N,SRAM_UB_N,SRAM_LB_N,SRAM_OE_N,SRAM_WE_N  out 1  SRAM controls, active-low
// BEHAVIOUR
//  Reset: state IDLE; all SRAM_*_N = 1; SRAM_DQ = Z; Mem_ready = 0; Data_to_CPU = 0; Hex_data = 0;
//    SRAM_ADDR = 0. Reset mid-access aborts it, with strobes high on the cycle after the edge.
//  Request: in IDLE, CE=0 and (OE=0 or WE=0). WE=0 has priority if both are low.
//    On acceptance ADDR, UB, LB and Data_from_CPU are latched; later input changes are ignored.
//  FSM states: IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, DONE, RELEASE.
//  Read, SRAM address:
//    IDLE -> RD_ACC.
//    RD_ACC holds SRAM_CE_N=0, SRAM_OE_N=0 and lanes = latched UB/LB for WAIT_CYCLES cycles.
//    On the last cycle's edge SRAM_DQ is captured into Data_to_CPU; lanes with UB/LB=1 read as 8'h00.
//    Then -> DONE.
//  Write, SRAM address:
//    WR_SETUP, 1 cycle: CE_N=0, DQ driven, WE_N=1.
//    WR_PULSE, WAIT_CYCLES cycles: WE_N=0.
//    WR_HOLD, 1 cycle: WE_N=1, DQ still driven.
//    Then -> DONE. SRAM_OE_N stays 1 for the whole write.
//  I/O (latched addr == IDLE-accepted IO_ADDR):
//    IDLE -> DONE directly.
//    A read loads Data_to_CPU = S; a write loads Hex_data = Data_from_CPU.
//    No SRAM strobe toggles.
//  Latency, counted from the accepting edge to the cycle Mem_ready=1:
//    SRAM read WAIT_CYCLES+1; SRAM write WAIT_CYCLES+3; I/O 1.
//  DONE: Mem_ready=1 for exactly one cycle, then -> RELEASE.
//  RELEASE: wait until CE=1 or (OE=1 and WE=1), then -> IDLE.
//    This guarantees one access per held strobe, so no re-trigger while the ISDU lingers.
//  Data_to_CPU holds its value until the next read completes; writes do not alter it.
//  SRAM_ADDR = zero-extended latched ADDR, stable from acceptance through DONE.
//  Wait counter: width ceil(log2(WAIT_CYCLES+1)); reloaded on every state entry, never wraps.
//  UB=LB=1 write: full sequence runs, both SRAM lanes stay disabled, Mem_ready still pulses.
// TESTING  (WAIT_CYCLES=2)
//  1. Hold Reset 2 cycles -> all SRAM_*_N=1, DQ=Z, Mem_ready=0, Hex_data=0, Data_to_CPU=0.
//  2. Write 16'h1234 to ADDR 16'h0005, UB=LB=0 -> SRAM_ADDR=20'h00005; SRAM_WE_N low exactly 2 cycles
//     with DQ=16'h1234; single Mem_ready pulse 5 cycles after acceptance.
//  3. Read 16'h0005 with OE held low 8 cycles -> Data_to_CPU=16'h1234 and Mem_ready at +3;
//     only one SRAM_OE_N window seen.
//  4. S=16'hBEEF, read ADDR 16'hFFFF -> Data_to_CPU=16'hBEEF, Mem_ready at +1, SRAM_CE_N stays 1;
//     write 16'h00AB to 16'hFFFF -> Hex_data=16'h00AB.
//  5. Write LB only (UB=1), data 16'hFFCD, to 16'h0005; read back -> SRAM model holds 16'h12CD;
//     read with UB=1 returns 16'h00CD.
//  6. Assert Reset during WR_PULSE -> SRAM_WE_N=1 and DQ=Z next cycle, no Mem_ready,
//     and the next request is handled normally.

Source files
------------

// File: rtl/mem_sram_ctrl.sv
// Memory-side stage between the LC-3 MAR/MDR strobes and an asynchronous 16-bit SRAM.
// Turns level-held strobes into timed SRAM cycles, decodes one I/O word, pulses Mem_ready per access.
module mem_sram_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF,
  parameter int unsigned SRAM_AW     = 20
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [15:0]        ADDR,
  input  logic               CE,
  input  logic               UB,
  input  logic               LB,
  input  logic               OE,
  input  logic               WE,
  input  logic [15:0]        Data_from_CPU,
  output logic [15:0]        Data_to_CPU,
  output logic               Mem_ready,
  input  logic [15:0]        S,
  output logic [15:0]        Hex_data,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N
);

  localparam int unsigned     CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD, DONE, RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ub_q, ub_d, lb_q, lb_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [SRAM_AW-1:0] saddr_q, saddr_d;
  logic [15:0]        dout_q, dout_d;
  logic [15:0]        hex_q, hex_d;
  logic               ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic               ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic               dq_oe_q, dq_oe_d;
  logic               ready_q, ready_d;
  logic               req;
  logic               sram_act;

  // Next-state, latching and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ub_d    = ub_q;
    lb_d    = lb_q;
    wdata_d = wdata_q;
    saddr_d = saddr_q;
    dout_d  = dout_q;
    hex_d   = hex_q;
    req     = !CE && (!OE || !WE);

    case (state_q)
      IDLE: begin
        if (req) begin
          ub_d    = UB;
          lb_d    = LB;
          wdata_d = Data_from_CPU;
          if (ADDR == IO_ADDR) begin
            state_d = DONE;
            if (!WE) hex_d = Data_from_CPU;
            else     dout_d = S;
          end else begin
            saddr_d = SRAM_AW'(ADDR);
            state_d = !WE ? WR_SETUP : RD_ACC;
          end
        end
      end
      RD_ACC: begin
        if (cnt_q == '0) begin
          dout_d  = {ub_q ? 8'h00 : SRAM_DQ[15:8], lb_q ? 8'h00 : SRAM_DQ[7:0]};
          state_d = DONE;
        end
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: if (cnt_q == '0) state_d = WR_HOLD;
      WR_HOLD:  state_d = DONE;
      DONE:     state_d = RELEASE;
      // One access per held strobe: wait for the processor to drop its request
      RELEASE:  if (CE || (OE && WE)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (state_d != state_q)  cnt_d = CNT_LOAD;
    else if (cnt_q != '0)    cnt_d = cnt_q - CNT_W'(1);

    sram_act = (state_d == RD_ACC) || (state_d == WR_SETUP) ||
               (state_d == WR_PULSE) || (state_d == WR_HOLD);
    ce_n_d   = !sram_act;
    oe_n_d   = (state_d != RD_ACC);
    we_n_d   = (state_d != WR_PULSE);
    ub_n_d   = !sram_act || ub_d;
    lb_n_d   = !sram_act || lb_d;
    dq_oe_d  = sram_act && (state_d != RD_ACC);
    ready_d  = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ub_q    <= 1'b1;
      lb_q    <= 1'b1;
      wdata_q <= '0;
      saddr_q <= '0;
      dout_q  <= '0;
      hex_q   <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ub_q    <= ub_d;
      lb_q    <= lb_d;
      wdata_q <= wdata_d;
      saddr_q <= saddr_d;
      dout_q  <= dout_d;
      hex_q   <= hex_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      dq_oe_q <= dq_oe_d;
      ready_q <= ready_d;
    end
  end

  assign SRAM_DQ     = dq_oe_q ? wdata_q : 16'hzzzz;
  assign Data_to_CPU = dout_q;
  assign Hex_data    = hex_q;
  assign Mem_ready   = ready_q;
  assign SRAM_ADDR   = saddr_q;
  assign SRAM_CE_N   = ce_n_q;
  assign SRAM_OE_N   = oe_n_q;
  assign SRAM_WE_N   = we_n_q;
  assign SRAM_UB_N   = ub_n_q;
  assign SRAM_LB_N   = lb_n_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: SRAM device model, transaction-level reference
// model with per-cycle comparison, and directed accesses with hand-computed expectations.
module tb_mem_sram_ctrl;

  localparam int W      = 2;
  localparam int K_NONE = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;
  localparam int K_IO   = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] ADDR, Data_from_CPU, S;
  logic        CE, UB, LB, OE, WE;
  logic [15:0] Data_to_CPU, Hex_data;
  logic        Mem_ready;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;
  wire  [15:0] sram_dq;

  int n_chk  = 0;
  int n_pass = 0;

  mem_sram_ctrl #(.WAIT_CYCLES(W), .IO_ADDR(16'hFFFF), .SRAM_AW(20)) dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Mem_ready(Mem_ready),
    .S(S), .Hex_data(Hex_data), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(sram_dq),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 Clk = ~Clk;

  // Undriven bus floats to all-ones so a stray driver is visible
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup pu (sram_dq[i]);
  end

  // SRAM device model
  logic [15:0] sram_mem [0:255];
  logic        dev_drv;
  assign dev_drv = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
  assign sram_dq = dev_drv ? sram_mem[SRAM_ADDR[7:0]] : 16'hzzzz;

  always @(posedge Clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_UB_N) sram_mem[SRAM_ADDR[7:0]][15:8] <= sram_dq[15:8];
      if (!SRAM_LB_N) sram_mem[SRAM_ADDR[7:0]][7:0]  <= sram_dq[7:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level reference model
  int          edge_n = 0;
  int          acc_e  = 0;
  int          kind   = K_NONE;
  int          m_lat  = 0;
  logic        m_busy = 1'b0;
  logic        chk_en = 1'b0;
  logic [7:0]  m_idx;
  logic [15:0] m_wdata;
  logic        m_ub, m_lb;
  logic [15:0] exp_data, exp_hex, r;
  logic [19:0] exp_saddr;
  logic [15:0] ref_mem [0:255];

  always @(posedge Clk) begin
    edge_n++;
    if (Reset) begin
      chk_en = 1'b1; m_busy = 1'b0; kind = K_NONE;
      exp_data = '0; exp_hex = '0; exp_saddr = '0;
    end else if (!m_busy) begin
      if (!CE && (!OE || !WE)) begin
        m_busy = 1'b1; acc_e = edge_n;
        m_idx = ADDR[7:0]; m_wdata = Data_from_CPU; m_ub = UB; m_lb = LB;
        if (ADDR == 16'hFFFF) begin
          kind = K_IO; m_lat = 1;
          if (!WE) exp_hex = Data_from_CPU;
          else     exp_data = S;
        end else begin
          kind      = !WE ? K_WR : K_RD;
          m_lat     = !WE ? W + 3 : W + 1;
          exp_saddr = {4'h0, ADDR};
        end
      end
    end else begin
      if (edge_n - acc_e == m_lat - 1) begin
        r = ref_mem[m_idx];
        if (kind == K_RD)
          exp_data = {m_ub ? 8'h00 : r[15:8], m_lb ? 8'h00 : r[7:0]};
        else if (kind == K_WR)
          ref_mem[m_idx] = {m_ub ? r[15:8] : m_wdata[15:8], m_lb ? r[7:0] : m_wdata[7:0]};
      end
      if ((edge_n - acc_e >= m_lat + 1) && (CE || (OE && WE))) begin
        m_busy = 1'b0; kind = K_NONE;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge Clk) begin
    int   o;
    logic e_ce, e_oe, e_we, e_ub, e_lb, e_rdy, e_drv, e_rdwin;
    if (chk_en) begin
      o = edge_n - acc_e;
      e_ce = 1; e_oe = 1; e_we = 1; e_ub = 1; e_lb = 1; e_rdy = 0; e_drv = 0; e_rdwin = 0;
      case (kind)
        K_RD: begin
          if (o < W) begin e_ce = 0; e_oe = 0; e_ub = m_ub; e_lb = m_lb; e_rdwin = 1; end
          e_rdy = (o == W);
        end
        K_WR: begin
          if (o <= W + 1) begin e_ce = 0; e_drv = 1; e_ub = m_ub; e_lb = m_lb; end
          e_we  = !(o >= 1 && o <= W);
          e_rdy = (o == W + 2);
        end
        K_IO:    e_rdy = (o == 0);
        default: ;
      endcase
      check("ce_n", SRAM_CE_N, e_ce);
      check("oe_n", SRAM_OE_N, e_oe);
      check("we_n", SRAM_WE_N, e_we);
      check("ub_n", SRAM_UB_N, e_ub);
      check("lb_n", SRAM_LB_N, e_lb);
      check("mem_ready", Mem_ready, e_rdy);
      check("data_to_cpu", Data_to_CPU, exp_data);
      check("hex_data", Hex_data, exp_hex);
      check("sram_addr", SRAM_ADDR, exp_saddr);
      if (e_drv)         check("dq_wr", sram_dq, m_wdata);
      else if (!e_rdwin) check("dq_z", sram_dq, 16'hFFFF);
    end
  end

  // Event counters for window/pulse counting
  int   ready_cnt, we_low_cnt, ce_low_cnt, oe_win_cnt;
  logic oe_prev = 1'b1;
  always @(negedge Clk) begin
    if (Mem_ready)                ready_cnt++;
    if (!SRAM_WE_N)               we_low_cnt++;
    if (!SRAM_CE_N)               ce_low_cnt++;
    if (!SRAM_OE_N && oe_prev)    oe_win_cnt++;
    oe_prev = SRAM_OE_N;
  end

  task automatic clr_mon();
    ready_cnt = 0; we_low_cnt = 0; ce_low_cnt = 0; oe_win_cnt = 0;
  endtask

  // One processor access; inputs are scrambled after acceptance to prove latching
  task automatic access(input logic wr, input logic both, input logic [15:0] a,
                        input logic [15:0] d, input logic ub, input logic lb,
                        input int hold, output int lat);
    @(posedge Clk); #1;
    ADDR = a; Data_from_CPU = d; UB = ub; LB = lb;
    CE = 1'b0; WE = !wr; OE = wr ? !both : 1'b0;
    @(posedge Clk); #1;
    ADDR = ~a; Data_from_CPU = ~d; UB = !ub; LB = !lb;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge Clk);
      if (Mem_ready) begin lat = n; break; end
    end
    repeat (hold) @(posedge Clk);
    #1;
    CE = 1'b1; OE = 1'b1; WE = 1'b1;
    repeat (2) @(posedge Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic found;
    for (int i = 0; i < 256; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
    clr_mon();
    CE = 1; OE = 1; WE = 1; UB = 0; LB = 0; ADDR = '0; Data_from_CPU = '0; S = '0;
    Reset = 1;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ce_n", SRAM_CE_N, 1);
    check("rst_we_n", SRAM_WE_N, 1);
    check("rst_oe_n", SRAM_OE_N, 1);
    check("rst_ready", Mem_ready, 0);
    check("rst_data", Data_to_CPU, 16'h0000);
    check("rst_hex", Hex_data, 16'h0000);
    check("rst_dq", sram_dq, 16'hFFFF);
    Reset = 0;

    // Full-word SRAM write
    clr_mon();
    access(1, 0, 16'h0005, 16'h1234, 0, 0, 1, lat);
    check("wr_latency", lat, 5);
    check("wr_we_low_cycles", we_low_cnt, 2);
    check("wr_ready_pulses", ready_cnt, 1);
    check("wr_mem", sram_mem[5], 16'h1234);
    check("wr_sram_addr", SRAM_ADDR, 20'h00005);

    // Read with strobe held long after completion
    clr_mon();
    access(0, 0, 16'h0005, 16'h0000, 0, 0, 5, lat);
    check("rd_latency", lat, 3);
    check("rd_data", Data_to_CPU, 16'h1234);
    check("rd_oe_windows", oe_win_cnt, 1);
    check("rd_ready_pulses", ready_cnt, 1);

    // I/O read of switches and write of hex register
    S = 16'hBEEF;
    clr_mon();
    access(0, 0, 16'hFFFF, 16'h0000, 0, 0, 1, lat);
    check("io_rd_latency", lat, 1);
    check("io_rd_data", Data_to_CPU, 16'hBEEF);
    check("io_rd_no_ce", ce_low_cnt, 0);
    clr_mon();
    access(1, 0, 16'hFFFF, 16'h00AB, 0, 0, 1, lat);
    check("io_wr_latency", lat, 1);
    check("io_wr_hex", Hex_data, 16'h00AB);
    check("io_wr_data_kept", Data_to_CPU, 16'hBEEF);
    check("io_wr_no_ce", ce_low_cnt, 0);

    // Byte-lane writes and reads
    access(1, 0, 16'h0005, 16'hFFCD, 1, 0, 1, lat);
    check("lb_wr_mem", sram_mem[5], 16'h12CD);
    access(0, 0, 16'h0005, 16'h0000, 0, 0, 1, lat);
    check("lb_rd_full", Data_to_CPU, 16'h12CD);
    access(0, 0, 16'h0005, 16'h0000, 1, 0, 1, lat);
    check("lb_rd_ub_off", Data_to_CPU, 16'h00CD);

    // No-lane write still runs a full cycle
    clr_mon();
    access(1, 0, 16'h0005, 16'h7777, 1, 1, 1, lat);
    check("nolane_latency", lat, 5);
    check("nolane_ready", ready_cnt, 1);
    check("nolane_ce_cycles", ce_low_cnt, 4);
    check("nolane_mem", sram_mem[5], 16'h12CD);

    // OE and WE both low: write wins
    access(1, 1, 16'h0009, 16'h0F0F, 0, 0, 1, lat);
    check("prio_latency", lat, 5);
    access(0, 0, 16'h0009, 16'h0000, 0, 0, 1, lat);
    check("prio_rd", Data_to_CPU, 16'h0F0F);

    // Reset during the write pulse aborts the access
    clr_mon();
    @(posedge Clk); #1;
    ADDR = 16'h0007; Data_from_CPU = 16'hDEAD; UB = 0; LB = 0; CE = 0; WE = 0; OE = 1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (!SRAM_WE_N) begin found = 1'b1; break; end
    end
    check("abort_reached_pulse", found, 1);
    Reset = 1; CE = 1; WE = 1;
    @(posedge Clk); #1;
    check("abort_we_n", SRAM_WE_N, 1);
    check("abort_ce_n", SRAM_CE_N, 1);
    check("abort_dq", sram_dq, 16'hFFFF);
    Reset = 0;
    repeat (3) @(posedge Clk);
    #1;
    check("abort_no_ready", ready_cnt, 0);
    access(1, 0, 16'h0007, 16'h5A5A, 0, 0, 1, lat);
    check("post_abort_wr_latency", lat, 5);
    access(0, 0, 16'h0007, 16'h0000, 0, 0, 1, lat);
    check("post_abort_rd_latency", lat, 3);
    check("post_abort_rd", Data_to_CPU, 16'h5A5A);

    repeat (2) @(posedge Clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
